control_fsm: RTL and testbench
==============================

// Module: control_fsm
// PURPOSE
//  Multicycle sequencer for the 16-bit Tron datapath. Fetches an instruction word, decodes it and
//  drives every datapath strobe (register addresses, ALU/shift/bus selects, write enables, PC
//  controls) state by state. Sits between instruction/data memory and the datapath; one per core.
// PARAMETERS
//  WIDTH    16  datapath / immediate width
//  REGBITS  4   register address width
// PORTS
//  clk            in   1      system clock, all state on rising edge
//  reset          in   1      synchronous, active-high
//  instr_valid    in   1      instr_data holds the fetched word this cycle
//  instr_data     in   16     instruction word from memory
//  mem_ready      in   1      data memory completed load/store this cycle
//  instr_req      out  1      request instruction at datapath addressOut
//  mem_req        out  1      data memory access active; address = regA
//  instructionOp  out  8      IR[15:8], to datapath
//  immediate      out  WIDTH  decoded immediate (see BEHAVIOUR)
//  regAddA        out  4      source register = IR[3:0]
//  regAddB        out  4      dest/operand register = IR[11:8]
//  ALUOp          out  4      ALU operation
//  shiftOp        out  2      shifter operation
//  busOp          out  3      bus select: 0 IMM, 1 MEM, 2 ALU, 3 SHIFT, 4 PC
//  immMUX         out  1      1 = immediate replaces regA as second operand
//  regWrite, memWrite, flagWrite  out 1 each  write strobes (single-cycle pulses)
//  flagOp         out  4      branch condition = IR[11:8]
//  pcAdd, pcJump, pcBranch        out 1 each  PC update pulses, at most one high per cycle
//  halted         out  1      core stopped in HALT
// BEHAVIOUR
//  - Fields: op=IR[15:12], rd=IR[11:8], ext=IR[7:4], rs=IR[3:0]; imm8=IR[7:0].
//  - Decode: 0x0 R-ALU (ALUOp=ext, immMUX=0, busOp=ALU); 0x1-0x7 I-ALU (ALUOp={1'b0,op[2:0]},
//    immMUX=1, immediate=sext(imm8)); 0x8 SHIFT (shiftOp=ext[1:0], immMUX=ext[2], imm=zext(rs),
//    busOp=SHIFT); 0x9 LOAD; 0xA STOR; 0xB MOVI (busOp=IMM, immMUX=1, imm=sext(imm8));
//    0xC Bcond (flagOp=rd, imm=sext(imm8)); 0xD JUMP (imm=zext(imm8)); 0xF HALT; 0xE = NOP.
//  - States: FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding free; 3-bit register.
//  - FETCH: instr_req=1; stays until instr_valid; then IR<=instr_data, ->DECODE.
//  - DECODE: drive addresses/selects only, no strobes; ->MEM for LOAD/STOR, ->HALT for HALT,
//    else ->EXEC.
//  - EXEC (1 cycle): ALU/SHIFT/MOVI: regWrite=1, pcAdd=1; flagWrite=1 for op 0x0-0x7 only.
//    Bcond: pcBranch=1 (PC resolves taken/not-taken). JUMP: pcJump=1. NOP: pcAdd=1. ->FETCH.
//  - MEM: mem_req=1 until mem_ready. STOR: memWrite=1 in the mem_ready cycle with pcAdd=1,
//    ->FETCH. LOAD: on mem_ready ->WB. WB: busOp=MEM, regWrite=1, pcAdd=1, ->FETCH.
//  - HALT: halted=1, all strobes 0; left only by reset.
//  - Latency (zero-wait memory): ALU/branch/jump 3 cycles, STOR 3, LOAD 4. Wait states extend
//    FETCH/MEM 1:1; no timeout.
//  - Outputs are Moore-style decode of state+IR; strobes 0 outside the cycles listed.
//  - Reset (any state, incl. mid-MEM wait): state=FETCH, IR=0, all strobes/req/halted=0 next
//    cycle; a pending memory response is ignored.
//  - instr_valid outside FETCH and mem_ready outside MEM are ignored.
// TESTING
//  1. Reset, then 0x0512 (R-ALU ext=1) with instr_valid -> DECODE, EXEC with regWrite=flagWrite=
//     pcAdd=1, ALUOp=1, regAddA=2, regAddB=5, busOp=2; back in FETCH cycle 4.
//  2. 0x33F6 (I-ALU) -> immediate=0xFFF6, immMUX=1, ALUOp=3; 0xB3F6 MOVI -> busOp=0, flagWrite=0.
//  3. LOAD 0x9402 with mem_ready delayed 3 cycles -> mem_req high 4 cycles, WB regWrite=1 busOp=1,
//     single pcAdd.
//  4. STOR 0xA402, mem_ready immediate -> memWrite and pcAdd in same single cycle, regWrite never 1.
//  5. 0xC2FE then 0xD010 -> pcBranch=1 flagOp=2 imm=0xFFFE; pcJump=1 imm=0x0010; pcAdd=0 both.
//  6. HALT 0xF000 -> halted=1 held 20 cycles; reset asserted during LOAD MEM wait -> FETCH, no WB.

Source files
------------

// File: rtl/control_fsm_if.sv
// control_fsm_if: instruction/data memory handshake plus datapath control bundle for the Tron sequencer
interface control_fsm_if #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
);
    logic               instr_valid;
    logic [15:0]        instr_data;
    logic               mem_ready;
    logic               instr_req;
    logic               mem_req;
    logic [7:0]         instructionOp;
    logic [WIDTH-1:0]   immediate;
    logic [REGBITS-1:0] regAddA;
    logic [REGBITS-1:0] regAddB;
    logic [3:0]         ALUOp;
    logic [1:0]         shiftOp;
    logic [2:0]         busOp;
    logic               immMUX;
    logic               regWrite;
    logic               memWrite;
    logic               flagWrite;
    logic [3:0]         flagOp;
    logic               pcAdd;
    logic               pcJump;
    logic               pcBranch;
    logic               halted;

    modport master (
        input  instr_valid, instr_data, mem_ready,
        output instr_req, mem_req, instructionOp, immediate, regAddA, regAddB, ALUOp, shiftOp,
               busOp, immMUX, regWrite, memWrite, flagWrite, flagOp, pcAdd, pcJump, pcBranch, halted
    );

    modport slave (
        output instr_valid, instr_data, mem_ready,
        input  instr_req, mem_req, instructionOp, immediate, regAddA, regAddB, ALUOp, shiftOp,
               busOp, immMUX, regWrite, memWrite, flagWrite, flagOp, pcAdd, pcJump, pcBranch, halted
    );
endinterface

// File: rtl/control_fsm.sv
// control_fsm: multicycle fetch/decode/execute sequencer driving every Tron datapath strobe
module control_fsm #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input logic           clk,
    input logic           reset,
    control_fsm_if.master bus
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} stateType;

    stateType    state, nextState;
    logic [15:0] ir, nextIr;
    logic [3:0]  op, nextOp;
    logic        inExec, isAlu;
    logic        instrReq, memReq, storPending, regWrite, flagWrite, pcAddReg, pcJump, pcBranch, halted;

    assign op     = ir[15:12];
    assign nextIr = (state == FETCH && bus.instr_valid) ? bus.instr_data : ir;
    assign nextOp = nextIr[15:12];
    assign inExec = nextState == EXEC;
    assign isAlu  = nextOp <= 4'h8 || nextOp == 4'hB;

    // Next-state selection; memory and fetch handshakes only matter in their own states
    always_comb begin
        nextState = state;
        case (state)
            FETCH:   if (bus.instr_valid) nextState = DECODE;
            DECODE:  if (op == 4'h9 || op == 4'hA) nextState = MEM;
                     else if (op == 4'hF) nextState = HALT;
                     else nextState = EXEC;
            EXEC:    nextState = FETCH;
            MEM:     if (bus.mem_ready) begin
                         if (op == 4'hA) nextState = FETCH;
                         else nextState = WB;
                     end
            WB:      nextState = FETCH;
            default: nextState = state;
        endcase
    end

    // State, instruction register and strobes registered from the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            ir          <= '0;
            instrReq    <= 1'b0;
            memReq      <= 1'b0;
            storPending <= 1'b0;
            regWrite    <= 1'b0;
            flagWrite   <= 1'b0;
            pcAddReg    <= 1'b0;
            pcJump      <= 1'b0;
            pcBranch    <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= nextState;
            ir          <= nextIr;
            instrReq    <= nextState == FETCH;
            memReq      <= nextState == MEM;
            storPending <= nextState == MEM && nextOp == 4'hA;
            regWrite    <= (inExec && isAlu) || nextState == WB;
            flagWrite   <= inExec && nextOp <= 4'h7;
            pcAddReg    <= (inExec && (isAlu || nextOp == 4'hE)) || nextState == WB;
            pcJump      <= inExec && nextOp == 4'hD;
            pcBranch    <= inExec && nextOp == 4'hC;
            halted      <= nextState == HALT;
        end
    end

    // A store commits, and the PC advances, only in the cycle memory acknowledges it
    assign bus.memWrite      = storPending & bus.mem_ready;
    assign bus.pcAdd         = pcAddReg | (storPending & bus.mem_ready);
    assign bus.instr_req     = instrReq;
    assign bus.mem_req       = memReq;
    assign bus.regWrite      = regWrite;
    assign bus.flagWrite     = flagWrite;
    assign bus.pcJump        = pcJump;
    assign bus.pcBranch      = pcBranch;
    assign bus.halted        = halted;
    assign bus.instructionOp = ir[15:8];
    assign bus.regAddA       = REGBITS'(ir[3:0]);
    assign bus.regAddB       = REGBITS'(ir[11:8]);
    assign bus.flagOp        = ir[11:8];
    assign bus.ALUOp         = op == 4'h0 ? ir[7:4] : op <= 4'h7 ? {1'b0, op[2:0]} : 4'h0;
    assign bus.shiftOp       = op == 4'h8 ? ir[5:4] : 2'd0;
    assign bus.immMUX        = op == 4'h8 ? ir[6] : ((op != 4'h0 && op <= 4'h7) || op == 4'hB);
    assign bus.busOp         = op == 4'h8 ? 3'd3 : op == 4'h9 ? 3'd1 : op == 4'hB ? 3'd0 :
                               (op == 4'hC || op == 4'hD) ? 3'd4 : 3'd2;
    assign bus.immediate     = op == 4'h8 ? WIDTH'(ir[3:0]) : op == 4'hD ? WIDTH'(ir[7:0]) :
                               {{(WIDTH-8){ir[7]}}, ir[7:0]};
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed scenario bench for the Tron control sequencer
module tb_control_fsm;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    control_fsm_if b ();
    control_fsm dut (.clk(clk), .reset(reset), .bus(b));

    always #5 clk = ~clk;

    // Strobe vector: {instr_req, mem_req, regWrite, memWrite, flagWrite, pcAdd, pcJump, pcBranch, halted}
    function automatic logic [8:0] strobes();
        return {b.instr_req, b.mem_req, b.regWrite, b.memWrite, b.flagWrite, b.pcAdd, b.pcJump, b.pcBranch, b.halted};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fetch(input logic [15:0] w);
        b.instr_valid = 1'b1;
        b.instr_data  = w;
        tick();
        b.instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tests++; if (strobes() !== 9'h000) begin fails++; $display("FAIL reset_strobes got %h want %h", strobes(), 9'h000); end
        tests++; if (b.instructionOp !== 8'h00) begin fails++; $display("FAIL reset_ir got %h want %h", b.instructionOp, 8'h00); end
        tests++; if (b.immediate !== 16'h0000) begin fails++; $display("FAIL reset_imm got %h want %h", b.immediate, 16'h0000); end
        tick();
        tests++; if (strobes() !== 9'h100) begin fails++; $display("FAIL reset_fetch got %h want %h", strobes(), 9'h100); end
    endtask

    task automatic test_ralu();
        fetch(16'h0512);
        tests++; if (strobes() !== 9'h000) begin fails++; $display("FAIL ralu_decode_strobes got %h want %h", strobes(), 9'h000); end
        tests++; if (b.regAddA !== 4'd2) begin fails++; $display("FAIL ralu_regAddA got %h want %h", b.regAddA, 4'd2); end
        tests++; if (b.regAddB !== 4'd5) begin fails++; $display("FAIL ralu_regAddB got %h want %h", b.regAddB, 4'd5); end
        tests++; if (b.ALUOp !== 4'd1) begin fails++; $display("FAIL ralu_ALUOp got %h want %h", b.ALUOp, 4'd1); end
        tests++; if (b.busOp !== 3'd2) begin fails++; $display("FAIL ralu_busOp got %h want %h", b.busOp, 3'd2); end
        tests++; if (b.immMUX !== 1'b0) begin fails++; $display("FAIL ralu_immMUX got %h want %h", b.immMUX, 1'b0); end
        tick();
        tests++; if (strobes() !== 9'h058) begin fails++; $display("FAIL ralu_exec got %h want %h", strobes(), 9'h058); end
        tick();
        tests++; if (strobes() !== 9'h100) begin fails++; $display("FAIL ralu_refetch got %h want %h", strobes(), 9'h100); end
    endtask

    task automatic test_ialu_movi();
        fetch(16'h33F6);
        tests++; if (b.immediate !== 16'hFFF6) begin fails++; $display("FAIL ialu_imm got %h want %h", b.immediate, 16'hFFF6); end
        tests++; if (b.immMUX !== 1'b1) begin fails++; $display("FAIL ialu_immMUX got %h want %h", b.immMUX, 1'b1); end
        tests++; if (b.ALUOp !== 4'd3) begin fails++; $display("FAIL ialu_ALUOp got %h want %h", b.ALUOp, 4'd3); end
        tick();
        tests++; if (strobes() !== 9'h058) begin fails++; $display("FAIL ialu_exec got %h want %h", strobes(), 9'h058); end
        tick();
        fetch(16'hB3F6);
        tests++; if (b.busOp !== 3'd0) begin fails++; $display("FAIL movi_busOp got %h want %h", b.busOp, 3'd0); end
        tests++; if (b.immMUX !== 1'b1) begin fails++; $display("FAIL movi_immMUX got %h want %h", b.immMUX, 1'b1); end
        tests++; if (b.immediate !== 16'hFFF6) begin fails++; $display("FAIL movi_imm got %h want %h", b.immediate, 16'hFFF6); end
        tick();
        tests++; if (strobes() !== 9'h048) begin fails++; $display("FAIL movi_exec got %h want %h", strobes(), 9'h048); end
        tick();
        tests++; if (strobes() !== 9'h100) begin fails++; $display("FAIL movi_refetch got %h want %h", strobes(), 9'h100); end
    endtask

    task automatic test_shift_nop_ignore();
        fetch(16'h8345);
        tests++; if (b.shiftOp !== 2'd0 || b.immMUX !== 1'b1 || b.busOp !== 3'd3 || b.immediate !== 16'h0005) begin
            fails++; $display("FAIL shift_decode got %h/%h/%h/%h want 0/1/3/0005", b.shiftOp, b.immMUX, b.busOp, b.immediate);
        end
        tick();
        tests++; if (strobes() !== 9'h048) begin fails++; $display("FAIL shift_exec got %h want %h", strobes(), 9'h048); end
        tick();
        fetch(16'hE000);
        b.instr_valid = 1'b1;
        b.instr_data  = 16'hF000;
        tick();
        tests++; if (b.instructionOp !== 8'hE0) begin fails++; $display("FAIL ignore_valid_ir got %h want %h", b.instructionOp, 8'hE0); end
        tests++; if (strobes() !== 9'h008) begin fails++; $display("FAIL nop_exec got %h want %h", strobes(), 9'h008); end
        b.instr_valid = 1'b0;
        tick();
        tests++; if (strobes() !== 9'h100) begin fails++; $display("FAIL nop_refetch got %h want %h", strobes(), 9'h100); end
    endtask

    task automatic test_load();
        int memCnt = 0;
        int pcCnt  = 0;
        int rwCnt  = 0;
        fetch(16'h9402);
        tests++; if (strobes() !== 9'h000) begin fails++; $display("FAIL load_decode got %h want %h", strobes(), 9'h000); end
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) b.mem_ready = 1'b1;
            #1;
            memCnt += int'(b.mem_req);
            pcCnt  += int'(b.pcAdd);
            rwCnt  += int'(b.regWrite);
            tick();
        end
        b.mem_ready = 1'b0;
        tests++; if (memCnt !== 4) begin fails++; $display("FAIL load_mem_req_cycles got %0d want 4", memCnt); end
        tests++; if (pcCnt + rwCnt !== 0) begin fails++; $display("FAIL load_mem_early_strobes got %0d want 0", pcCnt + rwCnt); end
        tests++; if (strobes() !== 9'h048) begin fails++; $display("FAIL load_wb got %h want %h", strobes(), 9'h048); end
        tests++; if (b.busOp !== 3'd1) begin fails++; $display("FAIL load_wb_busOp got %h want %h", b.busOp, 3'd1); end
        tick();
        tests++; if (strobes() !== 9'h100) begin fails++; $display("FAIL load_refetch got %h want %h", strobes(), 9'h100); end
    endtask

    task automatic test_stor();
        fetch(16'hA402);
        tick();
        tests++; if (strobes() !== 9'h080) begin fails++; $display("FAIL stor_mem_wait got %h want %h", strobes(), 9'h080); end
        b.mem_ready = 1'b1;
        #1;
        tests++; if (strobes() !== 9'h0A8) begin fails++; $display("FAIL stor_commit got %h want %h", strobes(), 9'h0A8); end
        tick();
        b.mem_ready = 1'b0;
        tests++; if (strobes() !== 9'h100) begin fails++; $display("FAIL stor_refetch got %h want %h", strobes(), 9'h100); end
    endtask

    task automatic test_branch_jump();
        fetch(16'hC2FE);
        tests++; if (b.flagOp !== 4'd2) begin fails++; $display("FAIL branch_flagOp got %h want %h", b.flagOp, 4'd2); end
        tests++; if (b.immediate !== 16'hFFFE) begin fails++; $display("FAIL branch_imm got %h want %h", b.immediate, 16'hFFFE); end
        tick();
        tests++; if (strobes() !== 9'h002) begin fails++; $display("FAIL branch_exec got %h want %h", strobes(), 9'h002); end
        tick();
        fetch(16'hD010);
        tests++; if (b.immediate !== 16'h0010) begin fails++; $display("FAIL jump_imm got %h want %h", b.immediate, 16'h0010); end
        tick();
        tests++; if (strobes() !== 9'h004) begin fails++; $display("FAIL jump_exec got %h want %h", strobes(), 9'h004); end
        tick();
        tests++; if (strobes() !== 9'h100) begin fails++; $display("FAIL jump_refetch got %h want %h", strobes(), 9'h100); end
    endtask

    task automatic test_halt_reset();
        int bad = 0;
        fetch(16'hF000);
        tests++; if (strobes() !== 9'h000) begin fails++; $display("FAIL halt_decode got %h want %h", strobes(), 9'h000); end
        b.instr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (strobes() !== 9'h001) bad++;
        end
        b.instr_valid = 1'b0;
        tests++; if (bad !== 0) begin fails++; $display("FAIL halt_hold bad_cycles got %0d want 0", bad); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (strobes() !== 9'h000) begin fails++; $display("FAIL halt_reset got %h want %h", strobes(), 9'h000); end
        tick();
        fetch(16'h9402);
        tick();
        tests++; if (strobes() !== 9'h080) begin fails++; $display("FAIL rst_load_mem got %h want %h", strobes(), 9'h080); end
        tick();
        reset = 1'b1;
        b.mem_ready = 1'b1;
        tick();
        reset = 1'b0;
        b.mem_ready = 1'b0;
        tests++; if (strobes() !== 9'h000) begin fails++; $display("FAIL rst_mid_mem got %h want %h", strobes(), 9'h000); end
        tests++; if (b.instructionOp !== 8'h00) begin fails++; $display("FAIL rst_mid_mem_ir got %h want %h", b.instructionOp, 8'h00); end
        tick();
        tests++; if (strobes() !== 9'h100) begin fails++; $display("FAIL rst_no_wb got %h want %h", strobes(), 9'h100); end
    endtask

    initial begin
        reset         = 1'b1;
        b.instr_valid = 1'b0;
        b.instr_data  = 16'h0000;
        b.mem_ready   = 1'b0;
        test_reset();
        test_ralu();
        test_ialu_movi();
        test_shift_nop_ignore();
        test_load();
        test_stor();
        test_branch_jump();
        test_halt_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
